// File: rtl/stream_sink_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : stream_sink_checker
// Description : Valid/ready stream sink. Accepts a programmed number of beats
//               under LFSR-driven backpressure and checks them against an
//               incrementing sequence. Define STREAM_SINK_PROTO_CHECK_EN to
//               add the sticky upstream protocol checker (proto_err).
// Revision    : 1.0 - initial release
// ============================================================================
module stream_sink_checker #(
    parameter int          DATA_W = 32,
    parameter int          CNT_W  = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_start_val,
    input  logic [CNT_W-1:0]  cfg_num_beats,
    input  logic [7:0]        cfg_stall_thr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [7:0]         thr_q, thr_d;
    logic [DATA_W-1:0]  exp_q, exp_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [DATA_W-1:0]  fed_q, fed_d;
    logic [DATA_W-1:0]  fee_q, fee_d;
    logic               beat;

    assign beat = in_vld && in_rdy_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        num_d   = num_q;
        thr_d   = thr_q;
        exp_d   = exp_q;
        beat_d  = beat_q;
        err_d   = err_q;
        fed_d   = fed_q;
        fee_d   = fee_q;
        case (state_q)
            ST_RUN: begin
                lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
                if (beat) begin
                    beat_d = beat_q + 1'b1;
                    exp_d  = exp_q + 1'b1;
                    if (in_data != exp_q) begin
                        if (err_q != CNT_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        // err_cnt never returns to zero within a run, so zero means "no mismatch yet"
                        if (err_q == '0) begin
                            fed_d = in_data;
                            fee_d = exp_q;
                        end
                    end
                    if (beat_q == num_q - 1'b1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d   = cfg_num_beats;
                    thr_d   = cfg_stall_thr;
                    exp_d   = cfg_start_val;
                    beat_d  = '0;
                    err_d   = '0;
                    fed_d   = '0;
                    fee_d   = '0;
                    lfsr_d  = SEED;
                    state_d = (cfg_num_beats == '0) ? ST_DONE : ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Look at the post-edge LFSR so the first RUN cycle reflects SEED
        in_rdy_d = (state_d == ST_RUN) && (lfsr_d[7:0] >= thr_d);
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            in_rdy_q <= 1'b0;
            num_q    <= '0;
            thr_q    <= '0;
            exp_q    <= '0;
            beat_q   <= '0;
            err_q    <= '0;
            fed_q    <= '0;
            fee_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            in_rdy_q <= in_rdy_d;
            num_q    <= num_d;
            thr_q    <= thr_d;
            exp_q    <= exp_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            fed_q    <= fed_d;
            fee_q    <= fee_d;
        end
    end

    assign in_rdy         = in_rdy_q;
    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign beat_cnt       = beat_q;
    assign err_cnt        = err_q;
    assign first_err_data = fed_q;
    assign first_err_exp  = fee_q;

`ifdef STREAM_SINK_PROTO_CHECK_EN
    logic              prev_vld_q, prev_vld_d;
    logic              prev_rdy_q, prev_rdy_d;
    logic [DATA_W-1:0] prev_data_q, prev_data_d;
    logic              proto_q, proto_d;
    logic              viol;

    // A stalled beat must stay valid with unchanged data
    always_comb begin
        viol        = prev_vld_q && !prev_rdy_q && (!in_vld || (in_data != prev_data_q));
        proto_d     = proto_q || viol;
        prev_vld_d  = in_vld;
        prev_rdy_d  = in_rdy_q;
        prev_data_d = in_data;
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            prev_vld_q  <= 1'b0;
            prev_rdy_q  <= 1'b0;
            prev_data_q <= '0;
            proto_q     <= 1'b0;
        end else begin
            prev_vld_q  <= prev_vld_d;
            prev_rdy_q  <= prev_rdy_d;
            prev_data_q <= prev_data_d;
            proto_q     <= proto_d;
            if (viol) begin
                $display("%0t stream_sink_checker: upstream protocol violation", $time);
            end
        end
    end

    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_sink_checker.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for stream_sink_checker: cycle model built from the
// behavioural rules, randomized and directed runs, per-cycle output compare.
module tb_stream_sink_checker;

    localparam int          DW   = 32;
    localparam int          CW   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rstB = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_start_val = '0;
    logic [CW-1:0] cfg_num_beats = '0;
    logic [7:0]    cfg_stall_thr = '0;
    logic          busy, done, proto_err;
    logic [CW-1:0] beat_cnt, err_cnt;
    logic [DW-1:0] first_err_data, first_err_exp;

    always #5 clk = ~clk;

    stream_sink_checker #(.DATA_W(DW), .CNT_W(CW), .SEED(SEED)) dut (
        .clk(clk), .rstB(rstB), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .start(start), .cfg_start_val(cfg_start_val), .cfg_num_beats(cfg_num_beats),
        .cfg_stall_thr(cfg_stall_thr), .busy(busy), .done(done), .beat_cnt(beat_cnt),
        .err_cnt(err_cnt), .first_err_data(first_err_data), .first_err_exp(first_err_exp),
        .proto_err(proto_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] seq [65535];   // LFSR value seen on the n-th RUN cycle

    int          m_state = 0;   // 0 idle, 1 run, 2 done
    int          m_n, m_num, m_beats, m_errs;
    logic [7:0]  m_thr;
    logic [31:0] m_exp, m_fd, m_fe;
    bit          m_proto;
    bit          p_v, p_r;
    logic [31:0] p_d;
    bit          chk_en = 0;

    function automatic bit m_rdy();
        return (m_state == 1) && (seq[m_n % 65535][7:0] >= m_thr);
    endfunction

    always @(posedge clk) begin
        bit r;
        r = m_rdy();
        if (!rstB) begin
            m_state = 0; m_n = 0; m_num = 0; m_beats = 0; m_errs = 0; m_thr = 0;
            m_exp = 0; m_fd = 0; m_fe = 0; m_proto = 0; p_v = 0; p_r = 0; p_d = 0;
        end else begin
`ifdef STREAM_SINK_PROTO_CHECK_EN
            if (p_v && !p_r && (!in_vld || in_data !== p_d)) m_proto = 1;
`endif
            p_v = in_vld; p_r = r; p_d = in_data;
            if (m_state == 1) begin
                if (in_vld && r) begin
                    if (in_data !== m_exp) begin
                        if (m_errs == 0) begin m_fd = in_data; m_fe = m_exp; end
                        if (m_errs < 65535) m_errs++;
                    end
                    m_beats++;
                    m_exp = m_exp + 32'd1;
                    if (m_beats == m_num) m_state = 2;
                end
                m_n++;
            end else if (start) begin
                m_num = int'(cfg_num_beats); m_thr = cfg_stall_thr; m_exp = cfg_start_val;
                m_beats = 0; m_errs = 0; m_fd = 0; m_fe = 0; m_n = 0;
                m_state = (cfg_num_beats == 0) ? 2 : 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_rdy", in_rdy, m_rdy());
            check("busy", busy, m_state == 1);
            check("done", done, m_state == 2);
            check("beat_cnt", beat_cnt, CW'(m_beats));
            check("err_cnt", err_cnt, CW'(m_errs));
            check("first_err_data", first_err_data, m_fd);
            check("first_err_exp", first_err_exp, m_fe);
            check("proto_err", proto_err, m_proto);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] src_q[$];
    bit          pat[$];

    task automatic run_stream(input logic [31:0] sv, input int num, input logic [7:0] thr,
                              input int vld_pct, input int stop_at, output int rdy_hi);
        int  idx = 0;
        int  cycles = 0;
        bit  last_xfer = 0;
        bit  rdy_now;
        rdy_hi = 0;
        pat.delete();
        @(negedge clk);
        cfg_start_val = sv; cfg_num_beats = CW'(num); cfg_stall_thr = thr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cycles < 5000 && !(stop_at > 0 && m_beats >= stop_at)) begin
            if (last_xfer) begin idx++; in_vld = 1'b0; end
            if (!in_vld && idx < src_q.size() && int'($urandom_range(99, 0)) < vld_pct) begin
                in_vld = 1'b1; in_data = src_q[idx];
            end
            rdy_now = in_rdy;
            last_xfer = in_vld && rdy_now;
            if (rdy_now) rdy_hi++;
            pat.push_back(rdy_now);
            cycles++;
            @(negedge clk);
        end
        if (stop_at == 0) begin
            in_vld = 1'b0;
            check("run_completes", done, 1'b1);
        end
    endtask

    initial begin
        logic [15:0] mask, l;
        int          hi, hi2, diffs, zeros;
        bit          pat1[$];
        int          taps[4] = '{16, 14, 13, 11};

        mask = 0;
        foreach (taps[i]) mask |= 16'(1 << (taps[i] - 1));
        l = SEED;
        for (int i = 0; i < 65535; i++) begin
            seq[i] = l;
            l = (l >> 1) ^ (l[0] ? mask : 16'h0);
        end
        check("model_lfsr_step", seq[1], 16'hE270);

        rstB = 1'b0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_in_rdy", in_rdy, 0);
        rstB = 1'b1;

        // thr=0: ready every cycle, eight back-to-back beats
        src_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(32'(i));
        run_stream(32'h0, 8, 8'h00, 100, 0, hi);
        check("t1_rdy_cycles", hi, 8);
        check("t1_beat_cnt", beat_cnt, 8);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_done", done, 1);
        check("t1_rdy_after", in_rdy, 0);

        // backpressure pattern reproducible across runs
        src_q.delete();
        for (int i = 0; i < 100; i++) src_q.push_back(32'h10 + 32'(i));
        run_stream(32'h10, 100, 8'h80, 100, 0, hi);
        pat1 = pat;
        check("t2_beat_cnt", beat_cnt, 100);
        check("t2_err_cnt", err_cnt, 0);
        run_stream(32'h10, 100, 8'h80, 100, 0, hi2);
        diffs = 0; zeros = 0;
        for (int i = 0; i < pat.size() && i < pat1.size(); i++) begin
            if (pat[i] != pat1[i]) diffs++;
            if (!pat1[i]) zeros++;
        end
        check("t2_pattern_repeat", diffs, 0);
        check("t2_stall_seen", zeros > 0, 1);
        check("t2_beat_cnt2", beat_cnt, 100);

        // data wraps at all-ones
        src_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        run_stream(32'hFFFF_FFFE, 4, 8'h00, 70, 0, hi);
        check("t3_err_cnt", err_cnt, 0);
        check("t3_beat_cnt", beat_cnt, 4);

        // two mismatches; first one captured, no resync
        src_q = '{32'd0, 32'd1, 32'd9, 32'd3, 32'd7, 32'd5};
        run_stream(32'h0, 6, 8'h40, 80, 0, hi);
        check("t4_err_cnt", err_cnt, 2);
        check("t4_first_data", first_err_data, 32'd9);
        check("t4_first_exp", first_err_exp, 32'd2);

        // zero-beat run
        src_q.delete();
        run_stream(32'h5, 0, 8'h00, 100, 0, hi);
        check("t5_done", done, 1);
        check("t5_beat_cnt", beat_cnt, 0);
        check("t5_rdy_never", hi, 0);

        // randomized runs
        for (int r = 0; r < 14; r++) begin
            logic [31:0] sv;
            int          n;
            sv = $urandom();
            if (r % 3 == 0) sv = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
            n = int'($urandom_range(60, 1));
            src_q.delete();
            for (int i = 0; i < n; i++) begin
                logic [31:0] d;
                d = sv + 32'(i);
                if ($urandom_range(9, 0) == 0) d = d ^ (32'd1 << $urandom_range(31, 0));
                src_q.push_back(d);
            end
            run_stream(sv, n, 8'($urandom_range(8'hC0, 0)), int'($urandom_range(100, 30)), 0, hi);
            check("rand_beat_cnt", beat_cnt, CW'(n));
        end

        // reset mid-run after three beats; the beat in the reset cycle is dropped
        src_q.delete();
        for (int i = 0; i < 10; i++) src_q.push_back(32'h100 + 32'(i));
        run_stream(32'h100, 10, 8'h00, 100, 3, hi);
        rstB = 1'b0;
        @(negedge clk);
        rstB = 1'b1;
        in_vld = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_beat_cnt", beat_cnt, 0);
        check("t6_in_rdy", in_rdy, 0);
        check("t6_done", done, 0);

        // drop valid while stalled (in IDLE, ready is low)
        @(negedge clk);
        in_vld = 1'b1; in_data = 32'h55;
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
`ifdef STREAM_SINK_PROTO_CHECK_EN
        check("t7_proto_set", proto_err, 1);
`else
        check("t7_proto_off", proto_err, 0);
`endif
        src_q = '{32'd7, 32'd8, 32'd9};
        run_stream(32'd7, 3, 8'h00, 100, 0, hi);
`ifdef STREAM_SINK_PROTO_CHECK_EN
        check("t7_proto_sticky", proto_err, 1);
`else
        check("t7_proto_off2", proto_err, 0);
`endif
        rstB = 1'b0;
        @(negedge clk);
        rstB = 1'b1;
        check("t7_proto_reset", proto_err, 0);
        repeat (2) @(negedge clk);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_sink_checker.md
Name: stream_sink_checker

Overview:
- Consumer-side endpoint for the 32-bit valid/ready stream leaving the team's fifo (out_data/out_vld/out_rdy side).
- Accepts a programmed number of beats and drives ready with a reproducible pseudo-random backpressure pattern.
- Checks each beat against an incrementing expected sequence and reports beat/error counts plus the first mismatch.
- Used in block-level benches and as a built-in self-test sink downstream of fifo instances.

Parameters:
- DATA_W, 32, stream data width.
- CNT_W, 16, width of beat/error counters and cfg_num_beats.
- SEED, 16'hACE1, LFSR reset/reload value; must be nonzero.

Ports:
- clk  in  1  clock.
- rstB  in  1  reset.
- in_data  in  DATA_W  stream data from upstream (fifo out_data).
- in_vld  in  1  stream valid from upstream.
- in_rdy  out  1  stream ready to upstream; registered.
- start  in  1  single-cycle pulse; launches a run.
- cfg_start_val  in  DATA_W  first expected data value; sampled on start.
- cfg_num_beats  in  CNT_W  beats to accept; sampled on start.
- cfg_stall_thr  in  8  backpressure threshold; 0 = never stall; sampled on start.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- beat_cnt  out  CNT_W  beats accepted this run.
- err_cnt  out  CNT_W  mismatching beats; saturates at all-ones.
- first_err_data  out  DATA_W  received data of first mismatch.
- first_err_exp  out  DATA_W  expected data of first mismatch.
- proto_err  out  1  sticky upstream protocol violation (see Optional Feature).

Behaviour:
- Reset and clock:
  - Reset rstB, synchronous, active-low; clock clk.
  - Reset values: state IDLE; in_rdy, busy, done, proto_err = 0; beat_cnt, err_cnt, first_err_* = 0; LFSR = SEED.
- Handshake:
  - A beat transfers on a rising edge where in_vld && in_rdy.
  - in_rdy never depends combinationally on in_vld.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_rdy = 0.
  - start with cfg_num_beats != 0 -> RUN.
  - start with cfg_num_beats == 0 -> DONE next cycle, with counters cleared.
- On start (from IDLE or DONE):
  - Latch the three cfg inputs.
  - expected <= cfg_start_val.
  - beat_cnt, err_cnt, first_err_* <= 0.
  - LFSR <= SEED.
  - done <= 0.
  - proto_err is not cleared; only reset clears it.
- RUN:
  - LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances one step every RUN cycle.
  - in_rdy register <= (next state == RUN) && (LFSR[7:0] >= latched thr). in_rdy is therefore 1 on the first RUN cycle only if SEED[7:0] >= thr.
  - With thr = 0, in_rdy stays high for the whole run.
  - On each beat:
    - beat_cnt++.
    - expected <= expected + 1, modulo 2^DATA_W (all-ones wraps to 0).
    - If in_data != expected: err_cnt++ (saturating). If this is the first mismatch of the run, capture first_err_data and first_err_exp.
    - expected never resynchronises to received data.
  - Beat with beat_cnt == num_beats-1 -> DONE. in_rdy is 0 the following cycle, so no extra beat is accepted.
  - start during RUN is ignored.
- DONE:
  - done = 1; in_rdy = 0.
  - Counters and first_err_* hold until the next start.
- Reset asserted mid-run: returns to IDLE with reset values on the next edge; any beat presented in that cycle is not counted.

Optional Feature:
- Macro: STREAM_SINK_PROTO_CHECK_EN.
- Defined:
  - Register the previous cycle's in_vld, in_rdy and in_data.
  - If previous in_vld && !in_rdy, then current in_vld must be 1 and in_data must equal its previous value.
  - Violation -> proto_err set, sticky until reset; simulation also prints a $display message with the time.
- Not defined: proto_err tied to 0; no extra registers.

Test Plan:
- thr=0, start_val=0, num_beats=8, upstream always valid with 0..7 -> in_rdy high 8 consecutive cycles, beat_cnt=8, err_cnt=0, done=1, in_rdy=0 after the last beat.
- thr=8'h80, num_beats=100, correct sequence from 32'h10 -> some in_rdy=0 cycles; pattern identical on two successive runs; beat_cnt=100, err_cnt=0.
- start_val=32'hFFFF_FFFE, num_beats=4, data FFFFFFFE, FFFFFFFF, 0, 1 -> err_cnt=0 (wrap accepted).
- start_val=0, num_beats=6, data 0,1,9,3,7,5 -> err_cnt=2, first_err_data=9, first_err_exp=2.
- num_beats=0 start -> DONE the next cycle, beat_cnt=0, in_rdy never asserted. Separately, rstB low mid-run at beat 3 -> IDLE, all outputs at reset values.
- With STREAM_SINK_PROTO_CHECK_EN: drop in_vld while in_rdy=0 -> proto_err=1, held through later runs until reset. Without the macro, same stimulus -> proto_err=0.
